// File: rtl/arc4_pkg.sv
// Shared types and constants for the arc4 key-sweep controller and its plaintext scanner.
package arc4_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WAIT_CORE,
      LAUNCH,
      BUSY,
      LEN,
      SCAN,
      NEXT,
      FINISH
   } ctrl_state_t;

   typedef enum logic [1:0] {
      SC_IDLE,
      SC_LENGTH,
      SC_DATA
   } scan_phase_t;

   localparam logic [7:0] PRINT_LO_DEF = 8'h20;
   localparam logic [7:0] PRINT_HI_DEF = 8'h7E;
   localparam logic [7:0] LEN_ADDR     = 8'd0;

   function automatic logic is_printable(input logic [7:0] b,
                                         input logic [7:0] lo,
                                         input logic [7:0] hi);
      return (b >= lo) && (b <= hi);
   endfunction

endpackage

// File: rtl/pt_scanner.sv
// Walks a length-prefixed plaintext in pt_mem and reports whether every byte is printable.
module pt_scanner
   import arc4_pkg::*;
#(
   parameter logic [7:0] PRINT_LO = PRINT_LO_DEF,
   parameter logic [7:0] PRINT_HI = PRINT_HI_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] pt_rddata,
   output logic [7:0] pt_addr,
   output logic       busy,
   output logic       pass,
   output logic       fin
);

   scan_phase_t phase;
   logic [7:0]  addr_q;
   logic [7:0]  len_q;
   logic [7:0]  idx_q;
   logic        byte_ok;

   assign byte_ok = is_printable(pt_rddata, PRINT_LO, PRINT_HI);
   assign busy    = (phase != SC_IDLE);

   // While the length byte is on q, address 1 goes out at once so data streams
   // back-to-back; an empty message keeps the address at 0.
   assign pt_addr = (phase == SC_LENGTH) ?
                    ((pt_rddata == 8'd0) ? LEN_ADDR : 8'd1) : addr_q;

   // NOTE: every output of a combinational block gets a default first, so no
   // path through the case can leave it unassigned and infer a latch.
   always_comb begin
      fin = 1'b0;
      unique case (phase)
         SC_LENGTH: fin = (pt_rddata == 8'd0);
         SC_DATA:   fin = !byte_ok || (idx_q == len_q);
         default:   fin = 1'b0;
      endcase
   end

   // NOTE: state is updated with non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         phase  <= SC_IDLE;
         addr_q <= LEN_ADDR;
         len_q  <= 8'd0;
         idx_q  <= 8'd0;
         pass   <= 1'b0;
      end else begin
         unique case (phase)
            SC_IDLE: begin
               if (start) phase <= SC_LENGTH;
            end
            SC_LENGTH: begin
               len_q <= pt_rddata;
               idx_q <= 8'd1;
               if (pt_rddata == 8'd0) begin
                  pass  <= 1'b1;
                  phase <= SC_IDLE;
               end else begin
                  addr_q <= (pt_rddata == 8'd1) ? 8'd1 : 8'd2;
                  phase  <= SC_DATA;
               end
            end
            SC_DATA: begin
               if (fin) begin
                  pass   <= byte_ok;
                  addr_q <= LEN_ADDR;
                  phase  <= SC_IDLE;
               end else begin
                  idx_q <= idx_q + 8'd1;
                  // Hold at L so the address never runs past the message (and never wraps at 255).
                  if (addr_q != len_q) addr_q <= addr_q + 8'd1;
               end
            end
            default: phase <= SC_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/arc4_key_sweep.sv
// Drives one arc4 core through single-key or key-range decrypts and checks each plaintext for printability.
module arc4_key_sweep
   import arc4_pkg::*;
#(
   parameter int         KEY_W    = 24,
   parameter logic [7:0] PRINT_LO = PRINT_LO_DEF,
   parameter logic [7:0] PRINT_HI = PRINT_HI_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   output logic             rdy,
   input  logic             sweep,
   input  logic [KEY_W-1:0] key_lo,
   input  logic [KEY_W-1:0] key_hi,
   output logic             core_en,
   input  logic             core_rdy,
   output logic [KEY_W-1:0] core_key,
   output logic             pt_sel,
   output logic [7:0]       pt_addr,
   input  logic [7:0]       pt_rddata,
   output logic             key_valid,
   output logic             done
);

   ctrl_state_t      state;
   logic             sweep_q;
   logic [KEY_W-1:0] key_hi_q;
   logic             core_seen_low;
   logic             scan_start;
   logic             scan_busy;
   logic             scan_pass;
   logic             scan_fin;

   assign scan_start = (state == LEN);

   pt_scanner #(
      .PRINT_LO (PRINT_LO),
      .PRINT_HI (PRINT_HI)
   ) u_scanner (
      .clk       (clk),
      .rst       (rst),
      .start     (scan_start),
      .pt_rddata (pt_rddata),
      .pt_addr   (pt_addr),
      .busy      (scan_busy),
      .pass      (scan_pass),
      .fin       (scan_fin)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         rdy           <= 1'b1;
         core_en       <= 1'b0;
         pt_sel        <= 1'b0;
         key_valid     <= 1'b0;
         done          <= 1'b0;
         core_key      <= '0;
         sweep_q       <= 1'b0;
         key_hi_q      <= '0;
         core_seen_low <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (en) begin
                  sweep_q   <= sweep;
                  key_hi_q  <= key_hi;
                  core_key  <= key_lo;
                  done      <= 1'b0;
                  key_valid <= 1'b0;
                  rdy       <= 1'b0;
                  state     <= (sweep && (key_lo > key_hi)) ? FINISH : WAIT_CORE;
               end
            end
            WAIT_CORE: begin
               if (core_rdy) begin
                  core_en <= 1'b1;
                  state   <= LAUNCH;
               end
            end
            LAUNCH: begin
               core_en       <= 1'b0;
               core_seen_low <= 1'b0;
               state         <= BUSY;
            end
            BUSY: begin
               // A core_rdy still high from before the launch is not completion.
               if (!core_rdy) begin
                  core_seen_low <= 1'b1;
               end else if (core_seen_low) begin
                  pt_sel <= 1'b1;
                  state  <= LEN;
               end
            end
            LEN: state <= SCAN;
            SCAN: begin
               if (scan_fin || !scan_busy) begin
                  pt_sel <= 1'b0;
                  state  <= NEXT;
               end
            end
            NEXT: begin
               if (scan_pass || !sweep_q) begin
                  key_valid <= scan_pass;
                  state     <= FINISH;
               end else if (core_key == key_hi_q) begin
                  key_valid <= 1'b0;
                  state     <= FINISH;
               end else begin
                  core_key <= core_key + KEY_W'(1);
                  state    <= WAIT_CORE;
               end
            end
            FINISH: begin
               done   <= 1'b1;
               rdy    <= 1'b1;
               pt_sel <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_arc4_key_sweep.sv
// Bench for arc4_key_sweep: behavioural core + pt_mem model, reference search model, per-cycle protocol checks.
module tb_arc4_key_sweep;

   localparam int KW = 24;

   typedef enum int {SC_HI, SC_SWEEP, SC_ALLFAIL, SC_LEN0, SC_EDGE, SC_RAND} scen_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          en;
   logic          rdy;
   logic          sweep;
   logic [KW-1:0] key_lo;
   logic [KW-1:0] key_hi;
   logic          core_en;
   logic          core_rdy;
   logic [KW-1:0] core_key;
   logic          pt_sel;
   logic [7:0]    pt_addr;
   logic [7:0]    pt_rddata;
   logic          key_valid;
   logic          done;

   logic [7:0]    mem [256];

   int            n_checks = 0;
   int            n_errors = 0;
   int            cyc = 0;
   int            total_pulses = 0;
   int            launch_cyc = -1;
   int            en_cyc = 0;
   int            last_max_addr = 0;
   logic          poke_rdy = 1'b0;

   scen_t         scen = SC_HI;
   int unsigned   rseed = 0;
   int            bad_pos = 0;
   logic [7:0]    bad_val = 8'h00;

   int            res_pulses;
   logic [KW-1:0] res_key;
   logic          res_valid;
   logic [KW-1:0] rlo, rhi;
   logic          rsw;

   arc4_key_sweep dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .rdy       (rdy),
      .sweep     (sweep),
      .key_lo    (key_lo),
      .key_hi    (key_hi),
      .core_en   (core_en),
      .core_rdy  (core_rdy),
      .core_key  (core_key),
      .pt_sel    (pt_sel),
      .pt_addr   (pt_addr),
      .pt_rddata (pt_rddata),
      .key_valid (key_valid),
      .done      (done)
   );

   always #10 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) pt_rddata <= mem[pt_addr];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // ---------------- plaintext the core produces for each key ----------------
   function automatic logic [7:0] msg_len(input logic [KW-1:0] k);
      int unsigned kk;
      kk = k;
      case (scen)
         SC_HI:      return (k == 24'h00033C) ? 8'd2 : 8'd1;
         SC_SWEEP:   return (k == 24'd5) ? 8'd3 : 8'd4;
         SC_ALLFAIL: return 8'd3;
         SC_LEN0:    return 8'd0;
         SC_EDGE:    return 8'd255;
         default:    return 8'((kk * 7 + rseed) % 9);
      endcase
   endfunction

   function automatic logic [7:0] msg_byte(input logic [KW-1:0] k, input int i);
      int unsigned kk, len, pos;
      logic [7:0]  bad [4];
      kk  = k;
      bad = '{8'h00, 8'h1F, 8'h7F, 8'hFF};
      case (scen)
         SC_HI: begin
            if (k == 24'h00033C) return (i == 1) ? 8'h68 : 8'h69;
            return 8'h00;
         end
         SC_SWEEP: begin
            if (k == 24'd5) return (i == 1) ? 8'h4F : ((i == 2) ? 8'h4B : 8'h21);
            return (i == 1) ? 8'h07 : 8'h61;
         end
         SC_ALLFAIL: return (i == 2) ? 8'h7F : 8'h41;
         SC_LEN0:    return 8'h00;
         SC_EDGE: begin
            if (bad_pos != 0 && i == bad_pos) return bad_val;
            return (i % 2 == 1) ? 8'h20 : 8'h7E;
         end
         default: begin
            len = msg_len(k);
            if (len != 0 && (kk + rseed) % 5 != 0) begin
               pos = 1 + (kk * 3 + rseed) % len;
               if (int'(pos) == i) return bad[(kk + rseed) % 4];
            end
            return 8'(32'h20 + (kk + 13 * unsigned'(i) + rseed) % 95);
         end
      endcase
   endfunction

   // 0 when every byte 1..L is in 0x20..0x7E, else the index of the first bad byte
   function automatic int first_fail(input logic [KW-1:0] k);
      logic [7:0] b;
      int         l;
      l = int'(msg_len(k));
      for (int i = 1; i <= l; i++) begin
         b = msg_byte(k, i);
         if (b < 8'h20 || b > 8'h7E) return i;
      end
      return 0;
   endfunction

   // Reference search: which key ends the run, how many launches, and the verdict.
   function automatic void ref_run(input logic sw, input logic [KW-1:0] lo, input logic [KW-1:0] hi,
                                   output int pulses, output logic [KW-1:0] key, output logic valid);
      longint last;
      pulses = 0;
      key    = lo;
      valid  = 1'b0;
      if (sw && lo > hi) return;
      last = sw ? longint'(hi) : longint'(lo);
      for (longint k = longint'(lo); k <= last; k++) begin
         key = KW'(k);
         pulses++;
         if (first_fail(key) == 0) begin
            valid = 1'b1;
            return;
         end
      end
   endfunction

   // ---------------- arc4 core model ----------------
   initial begin
      logic [KW-1:0] lkey;
      int            hold, busy;
      core_rdy = 1'b1;
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      forever begin
         @(posedge clk);
         if (core_en && !rst) begin
            lkey = core_key;
            hold = $urandom_range(0, 2);
            busy = $urandom_range(2, 6);
            repeat (hold) @(posedge clk);
            #1 core_rdy = 1'b0;
            mem[0] = msg_len(lkey);
            for (int i = 1; i < 256; i++) mem[i] = msg_byte(lkey, i);
            repeat (busy) @(posedge clk);
            #1 core_rdy = 1'b1;
         end else if (poke_rdy) begin
            #1 core_rdy = 1'b0;
            repeat (2) @(posedge clk);
            #1 core_rdy = 1'b1;
         end
      end
   end

   // ---------------- per-cycle protocol and scan checks ----------------
   logic prev_core_en = 1'b0;
   logic prev_core_rdy = 1'b1;
   logic prev_done = 1'b0;
   logic in_scan = 1'b0;
   int   scan_start_cyc = 0;
   int   rise_cyc = 0;
   int   max_addr = 0;

   always @(negedge clk) begin
      int l, ff;
      if (rst) begin
         in_scan      = 1'b0;
         prev_core_en = 1'b0;
      end else begin
         if (core_rdy && !prev_core_rdy) rise_cyc = cyc;
         if (core_en) begin
            total_pulses++;
            if (launch_cyc < en_cyc) launch_cyc = cyc;
            check("core_en one-cycle", prev_core_en, 1'b0);
            check("core_en with pt_sel", pt_sel, 1'b0);
         end
         if (done && !prev_done) check("done rises with rdy", rdy, 1'b1);
         if (pt_sel && !in_scan) begin
            in_scan        = 1'b1;
            scan_start_cyc = cyc;
            max_addr       = 0;
            check("first scan address", pt_addr, 8'd0);
            check("core done to length read", cyc - rise_cyc, 1);
         end
         if (pt_sel && int'(pt_addr) > max_addr) max_addr = int'(pt_addr);
         if (in_scan && !pt_sel) begin
            in_scan = 1'b0;
            l  = int'(msg_len(core_key));
            ff = first_fail(core_key);
            if (ff == 0) begin
               check("scan cycles (pass)", cyc - scan_start_cyc, l + 2);
               check("scan last address (pass)", max_addr, l);
            end else begin
               check("scan abort bound", (cyc - scan_start_cyc) <= ff + 2, 1'b1);
               check("scan address bound", max_addr <= l, 1'b1);
            end
            last_max_addr = max_addr;
         end
         prev_core_en = core_en;
      end
      prev_core_rdy = core_rdy;
      prev_done     = done;
   end

   // ---------------- stimulus ----------------
   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic run(input logic sw, input logic [KW-1:0] lo, input logic [KW-1:0] hi, input string tag);
      int            n, base, exp_p;
      logic [KW-1:0] exp_k;
      logic          exp_v;
      ref_run(sw, lo, hi, exp_p, exp_k, exp_v);
      n = 0;
      while (!rdy && n < 1000) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      base   = total_pulses;
      sweep  = sw;
      key_lo = lo;
      key_hi = hi;
      en     = 1'b1;
      en_cyc = cyc;
      @(negedge clk);
      en = 1'b0;
      n  = 0;
      while (!done && n < 20000) begin
         @(negedge clk);
         n++;
      end
      if (!done) begin
         check({tag, " timeout waiting for done"}, 1'b0, 1'b1);
         apply_reset();
         return;
      end
      res_pulses = total_pulses - base;
      res_key    = core_key;
      res_valid  = key_valid;
      check({tag, " core_en pulses"}, res_pulses, exp_p);
      check({tag, " core_key"}, res_key, exp_k);
      check({tag, " key_valid"}, res_valid, exp_v);
      if (exp_p > 0) check({tag, " en to core_en"}, launch_cyc - en_cyc, 2);
   endtask

   initial begin
      int   n;
      logic saw_sel;
      int   base;
      rst    = 1'b1;
      en     = 1'b0;
      sweep  = 1'b0;
      key_lo = '0;
      key_hi = '0;
      apply_reset();

      check("reset rdy", rdy, 1'b1);
      check("reset core_en", core_en, 1'b0);
      check("reset pt_sel", pt_sel, 1'b0);
      check("reset pt_addr", pt_addr, 8'd0);
      check("reset key_valid", key_valid, 1'b0);
      check("reset done", done, 1'b0);
      check("reset core_key", core_key, 24'd0);

      scen = SC_HI;
      run(1'b0, 24'h00033C, 24'h000000, "single");
      check("single pulses literal", res_pulses, 1);
      check("single key literal", res_key, 24'h00033C);
      check("single valid literal", res_valid, 1'b1);

      scen = SC_SWEEP;
      run(1'b1, 24'd0, 24'd15, "sweep");
      check("sweep pulses literal", res_pulses, 6);
      check("sweep key literal", res_key, 24'd5);
      check("sweep valid literal", res_valid, 1'b1);

      scen = SC_ALLFAIL;
      run(1'b1, 24'hFFFFFE, 24'hFFFFFF, "exhaust");
      check("exhaust pulses literal", res_pulses, 2);
      check("exhaust key literal", res_key, 24'hFFFFFF);
      check("exhaust valid literal", res_valid, 1'b0);
      run(1'b0, 24'h000040, 24'h000010, "single fail");

      run(1'b1, 24'd9, 24'd3, "empty range");
      check("empty pulses literal", res_pulses, 0);
      check("empty done literal", done, 1'b1);

      scen = SC_LEN0;
      run(1'b1, 24'd10, 24'd20, "length zero");
      check("len0 key literal", res_key, 24'd10);
      check("len0 valid literal", res_valid, 1'b1);

      scen    = SC_EDGE;
      bad_pos = 0;
      run(1'b0, 24'd7, 24'd7, "edge pass");
      check("edge last address literal", last_max_addr, 255);
      check("edge pass valid literal", res_valid, 1'b1);
      bad_pos = 255;
      bad_val = 8'h7F;
      run(1'b0, 24'd7, 24'd7, "edge 7F");
      check("edge 7F valid literal", res_valid, 1'b0);
      bad_pos = 100;
      bad_val = 8'h1F;
      run(1'b1, 24'd7, 24'd8, "edge 1F");
      check("edge 1F pulses literal", res_pulses, 2);

      // reset in the middle of a long scan
      bad_pos = 0;
      @(negedge clk);
      sweep  = 1'b0;
      key_lo = 24'd3;
      en     = 1'b1;
      en_cyc = cyc;
      @(negedge clk);
      en = 1'b0;
      n  = 0;
      while (!pt_sel && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("reaches scan before reset", pt_sel, 1'b1);
      repeat (20) @(negedge clk);
      @(posedge clk);
      #2 rst = 1'b1;
      @(posedge clk);
      #1;
      check("mid-scan reset rdy", rdy, 1'b1);
      check("mid-scan reset pt_sel", pt_sel, 1'b0);
      check("mid-scan reset done", done, 1'b0);
      check("mid-scan reset key_valid", key_valid, 1'b0);
      rst = 1'b0;
      base    = total_pulses;
      saw_sel = 1'b0;
      @(negedge clk);
      poke_rdy = 1'b1;
      @(negedge clk);
      poke_rdy = 1'b0;
      repeat (10) begin
         @(negedge clk);
         saw_sel = saw_sel | pt_sel;
      end
      check("stray core_rdy rise pt_sel", saw_sel, 1'b0);
      check("stray core_rdy rise pulses", total_pulses - base, 0);
      check("stray core_rdy rise rdy", rdy, 1'b1);

      for (int r = 0; r < 12; r++) begin
         scen  = SC_RAND;
         rseed = $urandom_range(0, 999);
         rlo   = KW'($urandom_range(0, 60));
         rhi   = rlo + KW'($urandom_range(0, 12));
         if ($urandom_range(0, 7) == 0 && rlo != 0) rhi = rlo - KW'(1);
         rsw   = ($urandom_range(0, 3) != 0);
         run(rsw, rlo, rhi, "random");
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/arc4_key_sweep.md
# arc4_key_sweep

Parametrised controller that drives one `arc4` decrypt core through its `rdy`/`en` handshake. It generalises the single-shot decrypt launcher in two ways:
- **Single mode:** decrypts once with one key.
- **Sweep mode:** steps through a key range until the plaintext is entirely printable ASCII.

It sits at the task top level between the switch/KEY inputs, the `arc4` core and `pt_mem`. It shares the `pt_mem` read port with the core through a select line.

## Interface
Parameters:
- `KEY_W`, 24, width of key, key bounds and core key.
- `PRINT_LO`, 8'h20, lowest byte value accepted as printable.
- `PRINT_HI`, 8'h7E, highest byte value accepted as printable.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock (CLOCK_50 at top).
- `rst`  in  1  synchronous active-high reset. The top level derives it from ~KEY[3] and feeds the same reset to the core.
- `en`  in  1  start request; sampled only while `rdy`=1.
- `rdy`  out  1  controller idle and accepting `en`.
- `sweep`  in  1  0 = single key, 1 = range search; sampled with `en`.
- `key_lo`  in  KEY_W  first key, or the only key in single mode; sampled with `en`.
- `key_hi`  in  KEY_W  last key, inclusive; sampled with `en`.
- `core_en`  out  1  one-cycle start pulse to `arc4`.
- `core_rdy`  in  1  `arc4` ready.
- `core_key`  out  KEY_W  key currently under test.
- `pt_sel`  out  1  1 = controller owns the `pt_mem` address; 0 = core owns it.
- `pt_addr`  out  8  controller read address into `pt_mem`.
- `pt_rddata`  in  8  `pt_mem` q, one-cycle read latency.
- `key_valid`  out  1  last run produced a fully printable plaintext.
- `done`  out  1  last run finished; held until next accepted `en`.

## Operation
- **Reset values:** state IDLE, `rdy`=1, `core_en`=0, `pt_sel`=0, `pt_addr`=0, `key_valid`=0, `done`=0, `core_key`=0.
- **IDLE:** `rdy`=1. When `en`=1, latch `sweep`, `key_lo` and `key_hi`. Set `core_key`←`key_lo`, clear `done` and `key_valid`, then go to WAIT_CORE.
- **Empty range:** if `sweep`=1 and `key_lo`>`key_hi`, go straight to FINISH with `key_valid`=0.
- **WAIT_CORE:** wait for `core_rdy`=1, then go to LAUNCH.
- **LAUNCH:** `core_en`=1 for exactly one cycle, then go to BUSY.
- **BUSY:** wait for `core_rdy` to fall, then wait for it to rise. A rise seen before the fall is ignored.
- **LEN:** `pt_sel`=1, read `pt_mem[0]`, which is the message length L (length-prefixed format).
- **SCAN:** read `pt_mem[1..L]`, one address per cycle, pipelined. A byte fails if it is <`PRINT_LO` or >`PRINT_HI`.
  - The first failing byte aborts the scan. That key is a fail.
  - L=0 passes.
  - Addresses never exceed L; 8-bit address, so L=255 ends at address 255 with no wrap.
- **NEXT:**
  - Pass, or `sweep`=0 → FINISH with `key_valid` = pass.
  - Fail and `core_key`==`key_hi` → FINISH with `key_valid`=0.
  - Otherwise `core_key`++ and go to WAIT_CORE.
  - The comparison happens before the increment, so `key_hi` = all-ones never wraps.
- **FINISH:** `done`=1, `pt_sel`=0, then go to IDLE. `core_key` holds the found (or last tried) key.
- **Reset mid-operation:** next state is IDLE with all outputs at reset values. Any in-flight scan is discarded.
- **`en` while `rdy`=0:** ignored.

## Timing
- `en` sample to `core_en` pulse: 2 cycles if `core_rdy` is already 1.
- Core done (`core_rdy` rise) to the first `pt_addr`=0 cycle: 1 cycle.
- Scan of a length-L message with all bytes printable: L+2 cycles from the `pt_addr`=0 cycle to NEXT (one read latency for the length byte, one for the last data byte).
- An abort on byte k reaches NEXT at most k+2 cycles after the length read.
- `pt_sel` is 1 only in LEN and SCAN. It is never 1 in the same cycle as `core_en`.
- `done`, `key_valid` and `rdy` are registered. `done` and `rdy` rise in the same cycle.

## Structure
- Package `arc4_pkg` holds:
  - the state enum (IDLE, WAIT_CORE, LAUNCH, BUSY, LEN, SCAN, NEXT, FINISH);
  - the `PRINT_LO`/`PRINT_HI` default constants;
  - the message-length address constant 8'd0.
- Sub-module `pt_scanner` is natural. It takes `start` and returns `busy`, `pass` and `fin`, drives `pt_addr`, and owns the LEN/SCAN pipeline and the printable compare. The parent FSM keeps the key iteration and the core handshake.

## Test plan
- **Single mode:** `sweep`=0, `key_lo`=24'h00033C, core model gives plaintext "hi" (L=2). Expect one `core_en` pulse, then `done`=1, `key_valid`=1, `core_key`=24'h00033C.
- **Sweep:**
  - Stimulus: `key_lo`=0, `key_hi`=15.
  - Core model: printable output only for key 5; a 0x07 byte at index 1 for all other keys.
  - Expected: exactly 6 `core_en` pulses, `core_key`=5, `key_valid`=1. Each failing scan aborts after reading address 1.
- **Exhaust and boundary:**
  - Stimulus: `key_lo`=24'hFFFFFE, `key_hi`=24'hFFFFFF, all keys fail.
  - Expected: 2 pulses, `key_valid`=0, `core_key`=24'hFFFFFF, no wrap to 0.
- **Degenerate ranges:**
  - `key_lo`=9, `key_hi`=3, `sweep`=1: `done`=1 with zero `core_en` pulses.
  - L=0: pass on the first key.
- **Printable edges:** L=255 with bytes 0x20 and 0x7E passes, and the last address read is 255. Replacing one byte with 0x7F or 0x1F fails.
- **Reset mid-scan:** assert `rst` for 1 cycle during SCAN. Next cycle: `rdy`=1, `pt_sel`=0, `done`=0, `key_valid`=0. A `core_rdy` rise is ignored until a new `en`.
